instr_fetch_unit: RTL

- Fetch stage of the RV32 core: owns the PC, issues single-outstanding reads to instruction memory, and presents the fetched word to decode with a valid/ready handshake.
- Drives the opcode/funct3 fields into the control unit.
- Consumes the control unit's PC_Src decision plus the branch/jump target to select the next PC.

---
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32 fetch stage. Owns the PC, issues one outstanding
// instruction-memory read at a time and hands the fetched word to decode
// over a valid/ready handshake. opcode/funct3 are sliced straight from the
// instruction register for the control unit.
// Optional build macro IFU_MISALIGN_CHECK_EN adds misalign_err and a
// terminal HALT state entered on a redirect to a non-word-aligned target.
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic            misalign_err
`endif
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    S_HALT
`endif
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_started;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            w_handshake;
  logic            w_capture;
  logic            w_misalign;

  assign w_handshake = (r_state == S_HOLD) && instr_ready;
  // Response is only meaningful while a request is outstanding.
  assign w_capture   = (r_state == S_WAIT) && imem_rvalid;

`ifdef IFU_MISALIGN_CHECK_EN
  logic r_misalign;
  assign w_misalign   = pc_src && (pc_target[1:0] != 2'b00);
  assign misalign_err = r_misalign;
`else
  assign w_misalign   = 1'b0;
`endif

  // State register; r_started holds off the first request until the first
  // edge after reset release, so imem_req stays low throughout reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_started <= 1'b1;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: if (r_started) w_next = S_WAIT;
      S_WAIT:  if (imem_rvalid) w_next = S_HOLD;
      S_HOLD: begin
        if (w_handshake) begin
`ifdef IFU_MISALIGN_CHECK_EN
          w_next = w_misalign ? S_HALT : S_FETCH;
`else
          w_next = S_FETCH;
`endif
        end
      end
      default: w_next = r_state;
    endcase
  end

  // Moore outputs derived from the current state.
  always_comb begin
    imem_req    = (r_state == S_FETCH) && r_started;
    imem_addr   = imem_req ? r_pc : '0;
    instr_valid = (r_state == S_HOLD);
  end

  // PC and fetched-instruction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      if (w_capture) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_pc;
      end
      if (w_handshake && !w_misalign) begin
        r_pc <= pc_src ? pc_target : r_pc + XLEN'(4);
      end
    end
  end

`ifdef IFU_MISALIGN_CHECK_EN
  // Sticky error flag; cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (w_handshake && w_misalign) begin
      r_misalign <= 1'b1;
    end
  end
`endif

  assign instr    = r_instr;
  assign instr_pc = r_instr_pc;
  assign opcode   = r_instr[6:0];
  assign funct3   = r_instr[14:12];

endmodule
